mem_arbiter: RTL and testbench

Memory-side responder for the cache request interface. It accepts word requests from the instruction cache (read-only) and the data cache (read/write), grants one at a time to the single-ported RAM, and returns data and wait handshakes. Data-cache two-word block transfers are kept atomic. Instruction starvation is bounded. It sits between the `icache`/`dcache` pair and the RAM model.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_starve_ctr.sv | 33 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: arbiter states, RAM status codes, word type.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MIN_CTR_W  = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arbstate_t;

  // Starvation counter width: enough to hold the limit, never below 3 bits.
  function automatic int unsigned ctr_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < MIN_CTR_W) ? MIN_CTR_W : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter.
// slave: the arbiter's view; master: the caches/RAM environment's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants made while an instruction
// request was waiting; at_limit hands the next arbitration to the icache.
module arb_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned          CTR_W = ctr_width(STARVE_LIMIT);
  localparam logic [CTR_W-1:0]     LIMIT = CTR_W'(STARVE_LIMIT);

  logic [CTR_W-1:0] cnt;

  // Count up on inc, clear on clr, hold at the limit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT)) begin
      cnt <= cnt + CTR_W'(1);
    end
  end

  assign at_limit = (cnt >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to the icache or dcache, one
// word at a time. Two-word dcache blocks (daddr[2]==0 then 1) are held
// atomic; instruction starvation is bounded by STARVE_LIMIT data grants.
// Optional build macro MEM_ARB_STATS_EN adds dwords/iwords completion counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output word_t         dwords,
  output word_t         iwords
`endif
);

  arbstate_t state;
  arbstate_t next_state;

  logic  d_req;
  logic  access;
  logic  starve_inc;
  logic  starve_clr;
  logic  at_limit;
  logic  ram_ren;
  logic  ram_wen;
  word_t ram_addr;
  word_t ram_store;
  logic  d_done;
  logic  i_done;

  assign d_req  = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RAM_ACCESS);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB;
    end else begin
      state <= next_state;
    end
  end

  // Next state, RAM strobes and starvation counter controls.
  always_comb begin
    next_state = state;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state)
      ARB: begin
        if (d_req && (!bus.iREN || !at_limit)) begin
          next_state = DSERV;
          starve_inc = bus.iREN;
        end else if (bus.iREN) begin
          next_state = ISERV;
          starve_clr = 1'b1;
        end
      end
      DSERV: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (!d_req) begin
          // Request withdrawn (e.g. lone word after a lock): release, no strobe.
          next_state = ARB;
        end else begin
          ram_wen = bus.dWEN;
          ram_ren = bus.dREN & ~bus.dWEN;
          // First word of a block keeps the grant for the second word.
          if (access && bus.daddr[2]) begin
            next_state = ARB;
          end
        end
      end
      ISERV: begin
        ram_addr = bus.iaddr;
        ram_ren  = 1'b1;
        if (access || !bus.iREN) begin
          next_state = ARB;
        end
      end
      default: begin
        next_state = ARB;
      end
    endcase
  end

  assign d_done = (state == DSERV) && access;
  assign i_done = (state == ISERV) && access;

  // Handshake and RAM-side outputs.
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.dwait    = ~d_done;
  assign bus.iwait    = ~i_done;
  assign bus.dload    = d_done ? bus.ramload : '0;
  assign bus.iload    = i_done ? bus.ramload : '0;

`ifdef MEM_ARB_STATS_EN
  // Completed-word counters, wrapping at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dwords <= '0;
      iwords <= '0;
    end else begin
      if (d_done) dwords <= dwords + WORD_W'(1);
      if (i_done) iwords <= iwords + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model answers ACCESS immediately
// (or ERROR when force_err is set) with ramload = ramaddr ^ KEY.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam word_t KEY = 32'h5A5A_0000;

  logic CLK;
  logic nRST;
  logic force_err;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
  word_t dwords;
  word_t iwords;
  word_t dwords_snap;
`endif

  mem_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .dwords (dwords),
    .iwords (iwords)
`endif
  );

  assign bus.ramstate = (bus.ramREN || bus.ramWEN) ?
                        (force_err ? RAM_ERROR : RAM_ACCESS) : RAM_FREE;
  assign bus.ramload  = bus.ramREN ? (bus.ramaddr ^ KEY) : '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          blocks;
    logic        done;
    logic        dwait_at_grant;
    logic [31:0] nxt;

    n_checks   = 0;
    n_errors   = 0;
    force_err  = 1'b0;
    nRST       = 1'b0;
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b0;
    bus.daddr  = 32'h40;
    bus.dstore = '0;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;

    // Reset held with a data request pending.
    #12;
    chk("rst_ramREN",   32'(bus.ramREN),  32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN),  32'd0);
    chk("rst_ramaddr",  bus.ramaddr,      32'd0);
    chk("rst_ramstore", bus.ramstore,     32'd0);
    chk("rst_dload",    bus.dload,        32'd0);
    chk("rst_iload",    bus.iload,        32'd0);
    chk("rst_dwait",    32'(bus.dwait),   32'd1);
    chk("rst_iwait",    32'(bus.iwait),   32'd1);

    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rel_c1_ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    chk("rel_c2_ramREN",  32'(bus.ramREN), 32'd1);
    chk("rel_c2_ramaddr", bus.ramaddr,     32'h40);
    chk("rel_c2_dwait",   32'(bus.dwait),  32'd0);
    chk("rel_c2_dload",   bus.dload,       32'h5A5A_0040);
    bus.dREN = 1'b0;
    #1;
    chk("drop_ramREN", 32'(bus.ramREN), 32'd0);
    tick();

    // Data block 0x40/0x44 with an instruction fetch pending throughout.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h100;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    #1;
    chk("blk_arb_ramREN", 32'(bus.ramREN), 32'd0);
    chk("blk_arb_dwait",  32'(bus.dwait),  32'd1);
    tick();
    chk("blk_w0_dwait", 32'(bus.dwait), 32'd0);
    chk("blk_w0_dload", bus.dload,      32'h5A5A_0040);
    chk("blk_w0_iwait", 32'(bus.iwait), 32'd1);
    tick();
    bus.daddr = 32'h44;
    #1;
    chk("blk_w1_dwait",   32'(bus.dwait), 32'd0);
    chk("blk_w1_dload",   bus.dload,      32'h5A5A_0044);
    chk("blk_w1_ramaddr", bus.ramaddr,    32'h44);
    tick();
    bus.dREN = 1'b0;
    #1;
    chk("blk_bubble_ramREN", 32'(bus.ramREN), 32'd0);
    chk("blk_bubble_iwait",  32'(bus.iwait),  32'd1);
    tick();
    chk("blk_i_iwait",   32'(bus.iwait), 32'd0);
    chk("blk_i_iload",   bus.iload,      32'h5A5A_0100);
    chk("blk_i_ramaddr", bus.ramaddr,    32'h100);
    bus.iREN = 1'b0;
    tick();
    chk("blk_end_ramREN", 32'(bus.ramREN), 32'd0);

    // dWEN and dREN together: write wins.
    bus.dWEN   = 1'b1;
    bus.dREN   = 1'b1;
    bus.dstore = 32'hDEAD_BEEF;
    bus.daddr  = 32'h80;
    tick();
    chk("wr_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("wr_ramREN",   32'(bus.ramREN), 32'd0);
    chk("wr_ramstore", bus.ramstore,    32'hDEAD_BEEF);
    chk("wr_ramaddr",  bus.ramaddr,     32'h80);
    chk("wr_dwait",    32'(bus.dwait),  32'd0);
    bus.dWEN = 1'b0;
    bus.dREN = 1'b0;
    #1;
    chk("wr_drop_ramWEN", 32'(bus.ramWEN), 32'd0);
    tick();

    // Lone write to 0x3100 (first-word address), then request drops.
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h3100;
    bus.dstore = 32'h1;
    tick();
    chk("lone_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("lone_dwait",  32'(bus.dwait),  32'd0);
    bus.dWEN = 1'b0;
    #1;
    chk("lone_drop_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("lone_drop_ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    chk("lone_arb_ramWEN", 32'(bus.ramWEN), 32'd0);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h200;
    tick();
    chk("lone_next_iwait", 32'(bus.iwait), 32'd0);
    chk("lone_next_iload", bus.iload,      32'h5A5A_0200);
    bus.iREN = 1'b0;
    tick();

    // Continuous data blocks with iREN held: icache wins after 4 blocks.
    bus.iREN       = 1'b1;
    bus.iaddr      = 32'h300;
    bus.dREN       = 1'b1;
    bus.daddr      = 32'h40;
    nxt            = 32'h40;
    blocks         = 0;
    done           = 1'b0;
    dwait_at_grant = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      bus.daddr = nxt;
      #1;
      if (!bus.iwait) begin
        done           = 1'b1;
        dwait_at_grant = bus.dwait;
      end else if (!bus.dwait) begin
        if (bus.daddr[2]) begin
          blocks++;
          nxt = 32'h40;
        end else begin
          nxt = 32'h44;
        end
      end
    end
    chk("starve_done",   32'(done),           32'd1);
    chk("starve_blocks", 32'(blocks),         32'd4);
    chk("starve_dwait",  32'(dwait_at_grant), 32'd1);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    tick();
    tick();

    // RAM ERROR for three cycles, then ACCESS.
`ifdef MEM_ARB_STATS_EN
    dwords_snap = dwords;
`endif
    force_err = 1'b1;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("err_dwait_%0d", k), 32'(bus.dwait), 32'd1);
      chk($sformatf("err_dload_%0d", k), bus.dload,      32'd0);
    end
    tick();
    force_err = 1'b0;
    #1;
    chk("err_ok_dwait", 32'(bus.dwait), 32'd0);
    chk("err_ok_dload", bus.dload,      32'h5A5A_0044);
    tick();
    bus.dREN = 1'b0;
    #1;
    chk("err_end_ramREN", 32'(bus.ramREN), 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("stats_dwords_delta", dwords - dwords_snap, 32'd1);
`endif

    // Asynchronous reset in the middle of a grant.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    tick();
    chk("arst_pre_ramREN", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("arst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("arst_dwait",  32'(bus.dwait),  32'd1);
    bus.dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("arst_idle_ramREN", 32'(bus.ramREN), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
